// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: default sizing,
// depth derivation and elaboration-time parameter legality.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH       = 16;
    localparam int DEF_ADDR_WIDTH       = 4;
    localparam int DEF_ALMOST_FULL_LVL  = 12;
    localparam int DEF_ALMOST_EMPTY_LVL = 2;

    // Number of words addressed by a pointer of the given width.
    function automatic int fifo_depth(input int addr_width);
        return 32'sd1 <<< addr_width;
    endfunction

    // Almost-full must lie in 1..DEPTH, almost-empty in 0..DEPTH-1.
    function automatic bit fifo_params_legal(input int addr_width,
                                             input int almost_full_lvl,
                                             input int almost_empty_lvl);
        int depth;
        depth = fifo_depth(addr_width);
        return (addr_width >= 32'sd1) &&
               (almost_full_lvl >= 32'sd1) && (almost_full_lvl <= depth) &&
               (almost_empty_lvl >= 32'sd0) && (almost_empty_lvl <= depth - 32'sd1);
    endfunction

endpackage

// File: rtl/fifo_dual_addr_ram.sv
// Register-file RAM with independent write and read addresses. The read
// port is registered; when both ports hit the same address on one edge the
// read returns the word stored before that edge.
module fifo_dual_addr_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH_C = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH_C];
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Storage array write; contents are intentionally left unreset.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read; holds its value when no read is enabled.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO: pointer, occupancy and flag logic around a
// dual-address RAM. Sticky overflow/underflow, synchronous flush and a
// one-cycle read-valid strobe.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int ALMOST_FULL_LVL  = DEF_ALMOST_FULL_LVL,
    parameter int ALMOST_EMPTY_LVL = DEF_ALMOST_EMPTY_LVL
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iClear,
    input  logic                  iWriteEnable,
    input  logic [DATA_WIDTH-1:0] iDataIn,
    input  logic                  iReadEnable,
    output logic [DATA_WIDTH-1:0] oDataOut,
    output logic                  oDataValid,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic                  oAlmostFull,
    output logic                  oAlmostEmpty,
    output logic [ADDR_WIDTH:0]   oCount,
    output logic                  oOverflow,
    output logic                  oUnderflow
);

    localparam int DEPTH_C = fifo_depth(ADDR_WIDTH);

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT_C = (ADDR_WIDTH+1)'(DEPTH_C);
    localparam logic [ADDR_WIDTH:0]   AF_CNT_C    = (ADDR_WIDTH+1)'(ALMOST_FULL_LVL);
    localparam logic [ADDR_WIDTH:0]   AE_CNT_C    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_LVL);
    localparam logic [ADDR_WIDTH:0]   CNT_STEP_C  = (ADDR_WIDTH+1)'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] PTR_STEP_C  = (ADDR_WIDTH)'(1'b1);

    if (!fifo_params_legal(ADDR_WIDTH, ALMOST_FULL_LVL, ALMOST_EMPTY_LVL)) begin : g_bad_params
        $error("sync_fifo_ram: almost-full/almost-empty level out of range");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_r, wr_ptr_n_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_r, rd_ptr_n_s;
    logic [ADDR_WIDTH:0]   count_r,  count_n_s;
    logic                  valid_r,  valid_n_s;
    logic                  ovf_r,    ovf_n_s;
    logic                  udf_r,    udf_n_s;

    logic full_s;
    logic empty_s;
    logic rd_accept_s;
    logic wr_accept_s;
    logic rd_take_s;
    logic wr_take_s;

    assign full_s      = (count_r == DEPTH_CNT_C);
    assign empty_s     = (count_r == '0);
    assign rd_accept_s = iReadEnable & ~empty_s;
    // A full FIFO still takes a write when the same edge frees a slot.
    assign wr_accept_s = iWriteEnable & (~full_s | rd_accept_s);
    // Flush overrides any same-cycle traffic.
    assign rd_take_s   = rd_accept_s & ~iClear;
    assign wr_take_s   = wr_accept_s & ~iClear;

    // Next-state for pointers, occupancy, read strobe and sticky errors.
    always_comb begin
        wr_ptr_n_s = wr_ptr_r;
        rd_ptr_n_s = rd_ptr_r;
        count_n_s  = count_r;
        valid_n_s  = 1'b0;
        ovf_n_s    = ovf_r;
        udf_n_s    = udf_r;
        if (iClear) begin
            wr_ptr_n_s = '0;
            rd_ptr_n_s = '0;
            count_n_s  = '0;
            valid_n_s  = 1'b0;
            ovf_n_s    = 1'b0;
            udf_n_s    = 1'b0;
        end else begin
            if (wr_take_s) begin
                wr_ptr_n_s = wr_ptr_r + PTR_STEP_C;
            end else begin
                wr_ptr_n_s = wr_ptr_r;
            end
            if (rd_take_s) begin
                rd_ptr_n_s = rd_ptr_r + PTR_STEP_C;
            end else begin
                rd_ptr_n_s = rd_ptr_r;
            end
            case ({wr_take_s, rd_take_s})
                2'b10:   count_n_s = count_r + CNT_STEP_C;
                2'b01:   count_n_s = count_r - CNT_STEP_C;
                default: count_n_s = count_r;
            endcase
            valid_n_s = rd_take_s;
            ovf_n_s   = ovf_r | (iWriteEnable & full_s & ~rd_accept_s);
            udf_n_s   = udf_r | (iReadEnable & empty_s);
        end
    end

    // Control state registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_n_s;
            rd_ptr_r <= rd_ptr_n_s;
            count_r  <= count_n_s;
            valid_r  <= valid_n_s;
            ovf_r    <= ovf_n_s;
            udf_r    <= udf_n_s;
        end
    end

    fifo_dual_addr_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .Clock   (Clock),
        .Reset   (Reset),
        .wr_en   (wr_take_s),
        .wr_addr (wr_ptr_r),
        .wr_data (iDataIn),
        .rd_en   (rd_take_s),
        .rd_addr (rd_ptr_r),
        .rd_data (oDataOut)
    );

    assign oDataValid   = valid_r;
    assign oCount       = count_r;
    assign oFull        = full_s;
    assign oEmpty       = empty_s;
    assign oAlmostFull  = (count_r >= AF_CNT_C);
    assign oAlmostEmpty = (count_r <= AE_CNT_C);
    assign oOverflow    = ovf_r;
    assign oUnderflow   = udf_r;

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Self-checking bench for sync_fifo_ram: queue-based reference model
// compared every cycle, plus directed sequences with literal expectations.
module tb_sync_fifo_ram;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;
    localparam int AEL   = 2;

    logic          Clock;
    logic          Reset;
    logic          iClear;
    logic          iWriteEnable;
    logic [DW-1:0] iDataIn;
    logic          iReadEnable;
    logic [DW-1:0] oDataOut;
    logic          oDataValid;
    logic          oFull;
    logic          oEmpty;
    logic          oAlmostFull;
    logic          oAlmostEmpty;
    logic [AW:0]   oCount;
    logic          oOverflow;
    logic          oUnderflow;

    sync_fifo_ram #(
        .DATA_WIDTH       (DW),
        .ADDR_WIDTH       (AW),
        .ALMOST_FULL_LVL  (AFL),
        .ALMOST_EMPTY_LVL (AEL)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iClear       (iClear),
        .iWriteEnable (iWriteEnable),
        .iDataIn      (iDataIn),
        .iReadEnable  (iReadEnable),
        .oDataOut     (oDataOut),
        .oDataValid   (oDataValid),
        .oFull        (oFull),
        .oEmpty       (oEmpty),
        .oAlmostFull  (oAlmostFull),
        .oAlmostEmpty (oAlmostEmpty),
        .oCount       (oCount),
        .oOverflow    (oOverflow),
        .oUnderflow   (oUnderflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_valid;
    logic          m_ovf;
    logic          m_udf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // One edge of FIFO behaviour from the rules: clear wins, then read/write.
    task automatic model_step(input bit we, input logic [DW-1:0] din, input bit re, input bit clr);
        bit full, empty, racc, wacc;
        if (clr) begin
            q.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            full  = (q.size() == DEPTH);
            empty = (q.size() == 0);
            racc  = re && !empty;
            wacc  = we && (!full || racc);
            if (re && empty) m_udf = 1'b1;
            if (we && full && !racc) m_ovf = 1'b1;
            if (racc) begin
                m_dout  = q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (wacc) q.push_back(din);
        end
    endtask

    // Drive one cycle, advance the model on the edge, return just after it.
    task automatic cycle(input bit we, input logic [DW-1:0] din, input bit re, input bit clr);
        iWriteEnable = we;
        iDataIn      = din;
        iReadEnable  = re;
        iClear       = clr;
        @(posedge Clock);
        model_step(we, din, re, clr);
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge Clock) begin
        if (chk_en) begin
            chk("count",        32'(oCount),       32'(q.size()));
            chk("empty",        32'(oEmpty),       32'(q.size() == 0));
            chk("full",         32'(oFull),        32'(q.size() == DEPTH));
            chk("almost_full",  32'(oAlmostFull),  32'(q.size() >= AFL));
            chk("almost_empty", 32'(oAlmostEmpty), 32'(q.size() <= AEL));
            chk("valid",        32'(oDataValid),   32'(m_valid));
            chk("dout",         32'(oDataOut),     32'(m_dout));
            chk("overflow",     32'(oOverflow),    32'(m_ovf));
            chk("underflow",    32'(oUnderflow),   32'(m_udf));
        end
    end

    initial begin
        Reset        = 1'b1;
        iClear       = 1'b0;
        iWriteEnable = 1'b0;
        iReadEnable  = 1'b0;
        iDataIn      = '0;
        model_reset();
        #1 Reset = 1'b0;
        #2;
        chk_en = 1'b1;

        // Reset state
        chk("rst_count", 32'(oCount), 32'd0);
        chk("rst_empty", 32'(oEmpty), 32'd1);
        chk("rst_full",  32'(oFull),  32'd0);
        chk("rst_ae",    32'(oAlmostEmpty), 32'd1);
        chk("rst_af",    32'(oAlmostFull),  32'd0);
        chk("rst_valid", 32'(oDataValid),   32'd0);
        chk("rst_dout",  32'(oDataOut),     32'd0);
        chk("rst_flags", 32'({oOverflow, oUnderflow}), 32'd0);
        @(posedge Clock);
        @(posedge Clock);
        #1 Reset = 1'b1;

        // Fill 16, almost-full and full thresholds, overflow, ordered drain
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 16'(i), 1'b0, 1'b0);
            if (i == 10) chk("af_before_12", 32'(oAlmostFull), 32'd0);
            if (i == 11) chk("af_at_12",     32'(oAlmostFull), 32'd1);
            if (i == 14) chk("full_at_15",   32'(oFull),       32'd0);
        end
        chk("full_at_16",  32'(oFull),  32'd1);
        chk("count_at_16", 32'(oCount), 32'd16);
        cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
        chk("ovf_set",     32'(oOverflow), 32'd1);
        chk("count_ovf",   32'(oCount),    32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 16'h0000, 1'b1, 1'b0);
            chk("drain_valid", 32'(oDataValid), 32'd1);
            chk("drain_data",  32'(oDataOut),   32'(i));
        end
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("idle_valid", 32'(oDataValid), 32'd0);
        chk("hold_data",  32'(oDataOut),   32'h000F);

        // Full with simultaneous read/write across pointer wrap
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 16'(16'h0200 + i), 1'b1, 1'b0);
            chk("rw_full_count", 32'(oCount), 32'd16);
            chk("rw_full_flag",  32'(oFull),  32'd1);
            chk("rw_full_data",  32'(oDataOut),
                (i < 16) ? 32'(16'h0100 + i) : 32'(16'h0200 + i - 16));
        end
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("clr_count", 32'(oCount), 32'd0);
        chk("clr_ovf",   32'(oOverflow), 32'd0);

        // Simultaneous read/write from empty
        cycle(1'b1, 16'h1234, 1'b1, 1'b0);
        chk("rw_empty_udf",   32'(oUnderflow), 32'd1);
        chk("rw_empty_count", 32'(oCount),     32'd1);
        chk("rw_empty_valid", 32'(oDataValid), 32'd0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("rw_empty_data",  32'(oDataOut),   32'h1234);
        chk("rw_empty_vld2",  32'(oDataValid), 32'd1);

        // Clear with same-cycle write is discarded
        for (int i = 0; i < 7; i++) cycle(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0);
        cycle(1'b1, 16'hBEEF, 1'b0, 1'b1);
        chk("clrw_count", 32'(oCount), 32'd0);
        chk("clrw_empty", 32'(oEmpty), 32'd1);
        chk("clrw_flags", 32'({oOverflow, oUnderflow}), 32'd0);
        chk("clrw_dout",  32'(oDataOut), 32'h1234);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("clrw_udf",   32'(oUnderflow), 32'd1);
        chk("clrw_valid", 32'(oDataValid), 32'd0);
        chk("clrw_dout2", 32'(oDataOut),   32'h1234);

        // Asynchronous reset mid-stream with 5 words stored
        for (int i = 0; i < 6; i++) cycle(1'b1, 16'(16'h0400 + i), 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(oCount), 32'd5);
        #2;
        Reset = 1'b0;
        model_reset();
        #1;
        chk("arst_count", 32'(oCount),     32'd0);
        chk("arst_empty", 32'(oEmpty),     32'd1);
        chk("arst_valid", 32'(oDataValid), 32'd0);
        chk("arst_flags", 32'({oOverflow, oUnderflow}), 32'd0);
        chk("arst_dout",  32'(oDataOut),   32'd0);
        iWriteEnable = 1'b0;
        iReadEnable  = 1'b0;
        @(posedge Clock);
        #1 Reset = 1'b1;
        cycle(1'b1, 16'hA5A5, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("post_rst_data",  32'(oDataOut),   32'hA5A5);
        chk("post_rst_valid", 32'(oDataValid), 32'd1);

        // Random concurrent traffic in alternating write/read-biased phases
        for (int k = 0; k < 10000; k++) begin
            int wp;
            wp = ((k / 1000) % 2 == 0) ? 65 : 35;
            cycle(($urandom_range(99) < wp),
                  16'($urandom),
                  ($urandom_range(99) < 50),
                  ($urandom_range(499) == 0));
        end
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge Clock);
        #1;
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ram.md
Name: sync_fifo_ram

Overview:
- Parametrised synchronous FIFO: dual-address register-file RAM plus write/read pointer counters and an occupancy counter.
- Successor to the single-read-port RAM and up-counter primitives. Adds full/empty/almost flags, sticky error flags, synchronous flush and a read-valid handshake.
- Sits between producer and consumer blocks in the same clock domain. Used as the standard buffering element in datapaths.

Parameters:
- DATA_WIDTH, 16, width of each stored word.
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH words (default 16).
- ALMOST_FULL_LVL, 12, oAlmostFull asserted when count >= this value (1..DEPTH).
- ALMOST_EMPTY_LVL, 2, oAlmostEmpty asserted when count <= this value (0..DEPTH-1).

Ports:
- Clock  in  1  single clock; all logic on posedge.
- Reset  in  1  asynchronous, active-low reset.
- iClear  in  1  synchronous flush; empties FIFO, clears error flags.
- iWriteEnable  in  1  write request.
- iDataIn  in  DATA_WIDTH  write data.
- iReadEnable  in  1  read request.
- oDataOut  out  DATA_WIDTH  read data, registered.
- oDataValid  out  1  oDataOut holds newly read word this cycle.
- oFull  out  1  count == DEPTH.
- oEmpty  out  1  count == 0.
- oAlmostFull  out  1  count >= ALMOST_FULL_LVL.
- oAlmostEmpty  out  1  count <= ALMOST_EMPTY_LVL.
- oCount  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- oOverflow  out  1  sticky: write attempted while full and not accepted.
- oUnderflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset low, asynchronous: write pointer = 0, read pointer = 0, oCount = 0, oDataOut = 0, oDataValid = 0, oOverflow = 0, oUnderflow = 0. Result: oEmpty = 1, oFull = 0, oAlmostEmpty = 1, oAlmostFull = 0 (given ALMOST_FULL_LVL >= 1). RAM contents are not reset.
- Reset asserted mid-operation: all state above returns to reset values immediately. Stored words are discarded logically.
- Read accept = iReadEnable & !oEmpty.
- Write accept = iWriteEnable & (!oFull | read accept).
  - A write while full is accepted only when a read is accepted in the same cycle.
  - In that case write address equals read address. The RAM returns old data (read-before-write), so the read gets the oldest word.
- Simultaneous read and write when empty: write accepted, read rejected, oUnderflow set. oCount becomes 1.
- Accepted write: RAM[wr_ptr] <= iDataIn; wr_ptr increments modulo DEPTH (natural wrap of ADDR_WIDTH bits).
- Accepted read: oDataOut <= RAM[rd_ptr] on the same edge; rd_ptr increments modulo DEPTH. oDataValid = 1 for exactly the following cycle.
  - Latency: data is visible one cycle after the request edge.
  - oDataOut holds its value when no read is accepted.
- oCount update: +1 on write only, -1 on read only, unchanged on both or neither. Never exceeds DEPTH or drops below 0.
- Flags are combinational decodes of the registered oCount. They change the cycle after the causing edge.
- Overflow: iWriteEnable & oFull & !read accept sets oOverflow, which then holds until iClear or Reset. The data is dropped.
- Underflow: iReadEnable & oEmpty sets oUnderflow, which then holds until iClear or Reset. oDataValid stays 0 and oDataOut is unchanged.
- iClear has priority over same-cycle read and write:
  - pointers = 0, oCount = 0, oDataValid = 0, error flags = 0;
  - oDataOut unchanged;
  - a write in the same cycle is discarded.
- Data order is strict FIFO across pointer wrap-around. Sequential writes of DEPTH+k words, interleaved with reads, must read back in order.

Decomposition:
- Shared package fifo_pkg holds:
  - default width/depth constants;
  - a function computing DEPTH from ADDR_WIDTH;
  - a parameter-legality check (levels within range), evaluated at elaboration.
- One sub-module, fifo_dual_addr_ram:
  - DATA_WIDTH x DEPTH, separate read/write addresses;
  - registered read with read-old-data on address collision;
  - read port enabled only on read accept.
  - Pointer, count and flag logic stay in the top level.

Test Plan:
- Reset low mid-stream with 5 words stored -> oCount = 0, oEmpty = 1, oDataValid = 0, sticky flags 0, all asynchronously. Then write 0xA5A5 and read it back -> oDataOut = 0xA5A5 with oDataValid one cycle after the read edge.
- Write 16 words 0x0000..0x000F -> oAlmostFull rises after the 12th write, oFull after the 16th. A 17th write (0xDEAD) -> oOverflow = 1, oCount stays 16. Read 16 words -> values 0x0000..0x000F in order; 0xDEAD never appears.
- With the FIFO full, assert iWriteEnable and iReadEnable together for 20 cycles with incrementing data -> oCount stays 16, oFull stays 1, and the read sequence is continuous and ordered across pointer wrap.
- From empty, assert read and write together with data 0x1234 -> oUnderflow = 1, oCount = 1, no oDataValid. Next read -> 0x1234 with oDataValid.
- Fill to 7 words, then assert iClear together with a write of 0xBEEF -> oCount = 0, oEmpty = 1, oOverflow = oUnderflow = 0. A subsequent read sets oUnderflow; 0xBEEF is never output.
- Random concurrent read/write for 10k cycles against a reference queue model -> every oDataValid word matches, oCount matches, and flags are consistent with oCount every cycle.
